pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order core. It arbitrates per-stage stall and flush requests from an N-stage pipeline and drives per-stage stall and flush commands. It holds each flush for a programmable number of cycles and runs a stall watchdog and a stall-cycle performance counter. It sits beside the pipeline registers, and every stage register consumes its own `stall[i]`/`flush[i]` bit. Stage index 0 is the youngest stage (fetch) and index STAGES-1 is the oldest (writeback).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_prio_enc.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the stage registers.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_t;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_prio_enc.sv
// Highest-set-index priority encoder with a valid flag.
module prio_enc #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // Ascending scan: the last (highest) set bit overwrites earlier hits.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/flush arbitration with flush hold, stall watchdog and
// stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              timeout_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              flushing,
  output logic              timeout,
  output logic [31:0]       stall_cnt
);

  localparam int unsigned IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      HOLD_INIT = 4'(FLUSH_HOLD - 1);

  ctrl_state_t       state, state_nxt;
  logic [IW-1:0]     src, src_nxt;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [3:0]        hold_cnt, hold_nxt;
  logic [STAGES-1:0] flush_nxt;
  logic [STAGES-1:0] win_mask;
  logic [STAGES-1:0] eff_req;
  logic [WD_W-1:0]   wd_cnt;
  logic              any_stall;
  logic              acc;

  prio_enc #(.WIDTH(STAGES)) u_prio_enc (
    .req   (flush_req),
    .idx   (win_idx),
    .valid (win_vld)
  );

  always_comb begin
    win_mask = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      win_mask[i] = (i < 32'(win_idx));
    end
  end

  // Scan oldest to youngest so a blocked older stage backs up everything below it.
  assign eff_req = stall_req & ~flush;
  always_comb begin
    stall = '0;
    acc   = 1'b0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      acc |= eff_req[STAGES-1-j];
      stall[STAGES-1-j] = acc & ~flush[STAGES-1-j] & ~rst;
    end
  end

  assign any_stall = |stall;
  assign flushing  = (state == CTRL_FLUSH);

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    hold_nxt  = hold_cnt;
    flush_nxt = flush;
    case (state)
      CTRL_RUN: begin
        if (win_vld) begin
          state_nxt = CTRL_FLUSH;
          src_nxt   = win_idx;
          flush_nxt = win_mask;
          hold_nxt  = HOLD_INIT;
        end else begin
          flush_nxt = '0;
        end
      end
      CTRL_FLUSH: begin
        if (win_vld && (win_idx > src)) begin
          src_nxt   = win_idx;
          flush_nxt = win_mask;
          hold_nxt  = HOLD_INIT;
        end else if (hold_cnt == 4'd0) begin
          state_nxt = CTRL_RUN;
          flush_nxt = '0;
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = CTRL_RUN;
        flush_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CTRL_RUN;
      src      <= '0;
      hold_cnt <= '0;
      flush    <= '0;
    end else begin
      state    <= state_nxt;
      src      <= src_nxt;
      hold_cnt <= hold_nxt;
      flush    <= flush_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (any_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (timeout_clr) begin
        wd_cnt  <= '0;
        timeout <= 1'b0;
      end else if (any_stall) begin
        if (wd_cnt == WD_MAX) begin
          timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (STAGES=5, FLUSH_HOLD=2, TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stall_req;
  logic [4:0]  flush_req;
  logic        timeout_clr;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        flushing;
  logic        timeout;
  logic [31:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          step;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        flushing;
    logic        timeout;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pipe_hazard_ctrl #(
    .STAGES     (5),
    .FLUSH_HOLD (2),
    .TIMEOUT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .timeout_clr (timeout_clr),
    .stall       (stall),
    .flush       (flush),
    .flushing    (flushing),
    .timeout     (timeout),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input int step, input logic [4:0] e_stall, input logic [4:0] e_flush,
                      input logic e_fl, input logic e_to, input logic [31:0] e_cnt);
    exp_t e;
    e.step = step; e.stall = e_stall; e.flush = e_flush;
    e.flushing = e_fl; e.timeout = e_to; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    assert (stall === e.stall) else begin
      n_fail++;
      $error("FAIL stall step %0d: observed %b expected %b", e.step, stall, e.stall);
    end
    n_chk++;
    assert (flush === e.flush) else begin
      n_fail++;
      $error("FAIL flush step %0d: observed %b expected %b", e.step, flush, e.flush);
    end
    n_chk++;
    assert (flushing === e.flushing) else begin
      n_fail++;
      $error("FAIL flushing step %0d: observed %b expected %b", e.step, flushing, e.flushing);
    end
    n_chk++;
    assert (timeout === e.timeout) else begin
      n_fail++;
      $error("FAIL timeout step %0d: observed %b expected %b", e.step, timeout, e.timeout);
    end
    n_chk++;
    assert (stall_cnt === e.cnt) else begin
      n_fail++;
      $error("FAIL stall_cnt step %0d: observed %0d expected %0d", e.step, stall_cnt, e.cnt);
    end
  endtask

  // Drive at the falling edge, check just after, then cross one rising edge.
  task automatic cyc(input int step, input logic [4:0] sr, input logic [4:0] fr, input logic clr,
                     input logic [4:0] e_stall, input logic [4:0] e_flush,
                     input logic e_fl, input logic e_to, input logic [31:0] e_cnt);
    stall_req   = sr;
    flush_req   = fr;
    timeout_clr = clr;
    push(step, e_stall, e_flush, e_fl, e_to, e_cnt);
    #1;
    check_front();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_req = 5'b11111; flush_req = 5'b00000; timeout_clr = 1'b0;
    push(0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    #2;
    check_front();
    @(negedge clk);
    rst = 1'b0;

    // stall backup
    cyc( 1, 5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 1'b0, 1'b0, 32'd0);
    cyc( 2, 5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 1'b0, 1'b0, 32'd1);
    cyc( 3, 5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 1'b0, 1'b0, 32'd2);
    cyc( 4, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    // flush timing, hold of two cycles
    cyc( 5, 5'b00000, 5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    cyc( 6, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00011, 1'b1, 1'b0, 32'd3);
    cyc( 7, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00011, 1'b1, 1'b0, 32'd3);
    cyc( 8, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    // older source extends, younger source ignored
    cyc( 9, 5'b00000, 5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    cyc(10, 5'b00000, 5'b01000, 1'b0, 5'b00000, 5'b00011, 1'b1, 1'b0, 32'd3);
    cyc(11, 5'b00000, 5'b00010, 1'b0, 5'b00000, 5'b00111, 1'b1, 1'b0, 32'd3);
    cyc(12, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00111, 1'b1, 1'b0, 32'd3);
    cyc(13, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    // flush beats stall
    cyc(14, 5'b00000, 5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd3);
    cyc(15, 5'b00001, 5'b00000, 1'b0, 5'b00000, 5'b00011, 1'b1, 1'b0, 32'd3);
    cyc(16, 5'b01001, 5'b00000, 1'b0, 5'b01100, 5'b00011, 1'b1, 1'b0, 32'd3);
    cyc(17, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd4);
    // watchdog fires on the fourth stalled edge and is sticky
    cyc(18, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd4);
    cyc(19, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd5);
    cyc(20, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd6);
    cyc(21, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd7);
    cyc(22, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 32'd8);
    cyc(23, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b1, 32'd8);
    cyc(24, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd8);
    // clear on the would-be firing edge wins
    cyc(25, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd8);
    cyc(26, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd9);
    cyc(27, 5'b10000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd10);
    cyc(28, 5'b10000, 5'b00000, 1'b1, 5'b11111, 5'b00000, 1'b0, 1'b0, 32'd11);
    cyc(29, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd12);
    // async reset in the middle of a hold
    cyc(30, 5'b00000, 5'b01000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd12);
    stall_req = 5'b10000; flush_req = 5'b00000;
    push(31, 5'b11000, 5'b00111, 1'b1, 1'b0, 32'd12);
    #1;
    check_front();
    rst = 1'b1;
    push(32, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    #1;
    check_front();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(33, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    cyc(34, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
